as_rx_gen2: RTL and testbench
=============================

Name: as_rx_gen2

Overview:
Parametrised next-generation UART receiver for the ip_uart block. It adds internal 16x oversampling with a runtime divisor and majority-vote bit sampling. Runtime-selectable parity and stop-bit count are supported, along with false-start rejection and framing, parity, break and overrun detection. Received characters go out through a one-entry valid/ready holding register to the bus-side FIFO or register interface.

Parameters:
DATA_BITS, 8, character length, legal 5..9, LSB first on the line
DIV_W, 16, width of the oversample divisor port
OVS, 16, oversample ticks per bit, fixed to 16; other values are illegal

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
rx_i  in  1  serial line, asynchronous to clk_i, idle high
div_i  in  DIV_W  oversample divisor; one tick every div_i+1 clocks
par_mode_i  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2_i  in  1  0 = one stop bit, 1 = two stop bits
data_o  out  DATA_BITS  received character, valid while valid_o=1
valid_o  out  1  holding register full
ready_i  in  1  consumer accepts data_o when valid_o&&ready_i
frame_err_o  out  1  stop bit sampled 0; qualified by valid_o
par_err_o  out  1  parity mismatch; qualified by valid_o
break_o  out  1  one-cycle pulse: all data bits, parity (if enabled) and first stop bit sampled 0
overrun_o  out  1  one-cycle pulse: frame completed while holding register still full
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni=0, asynchronous): FSM to IDLE, all counters 0, and the synchroniser to 2'b11.
- Reset outputs: data_o=0, valid_o=0, frame_err_o=0, par_err_o=0, break_o=0, overrun_o=0, busy_o=0.
- Reset mid-frame aborts the frame; no partial character is delivered.
- Synchroniser: rx_i passes through 2 flops to give rx_s. Edge detection and sampling use rx_s only.
- Tick generator: counter runs 0..div_i and emits a tick on its terminal count. It is cleared on entry to START so bit timing aligns to the start edge. div_i=0 gives a tick every clock.
- Bit period is 16*(div_i+1) clocks.
- Config latch: div_i, par_mode_i and stop2_i are captured on IDLE->START. Changes during a frame have no effect until the next frame.
- Bit counter: ticks counted 0..15 within each bit. Samples are taken at ticks 7, 8 and 9. The bit value is the 2-of-3 majority, resolved on tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: falling edge of rx_s (previous 1, current 0) -> START.
- START: majority resolved 1 -> IDLE (false start; no outputs, no pulses). Majority resolved 0 -> continue; after tick 15 -> DATA, bit index 0.
- DATA: shift the resolved bit into position bit index. After tick 15 of bit DATA_BITS-1: -> PARITY if parity is enabled, else -> STOP1.
- PARITY: compare the resolved bit to the expected parity. Even: XOR of data bits. Odd: inverted XOR. After tick 15 -> STOP1.
- STOP1: on the tick-9 resolution, record frame_err if the bit is 0. If stop2=0, complete the frame immediately (no wait for ticks 10..15) and -> IDLE. Otherwise after tick 15 -> STOP2.
- STOP2: on the tick-9 resolution, OR its error into frame_err, complete the frame, -> IDLE.
- Early return to IDLE allows back-to-back frames with clock skew up to half a bit.
- Frame completion (one clock after the last stop-bit resolution):
  - Holding register empty, or being emptied this same cycle (valid_o&&ready_i): load data_o and the error flags, and set valid_o=1.
  - Holding register full and not being accepted: drop the new frame, keep the old data and flags, pulse overrun_o for 1 clock.
  - break_o pulses on completion whenever the break condition holds, even if the frame is dropped.
  - A break frame also has frame_err=1.
- Handshake: valid_o stays high until the cycle after valid_o&&ready_i. Data and flags are stable while valid_o=1. ready_i is ignored when valid_o=0.
- If a falling edge occurs in STOP1/STOP2 after the resolution, the FSM is already in IDLE, so the edge starts a new frame.
- A line held low continuously: one break frame, then no new start until rx_s returns high and falls again.

Test Plan:
- 8N1, div_i=3 (64 clk/bit): send 0xA5 -> valid_o rises 1 clock after the stop-bit tick-9 resolution; data_o=0xA5, frame_err_o=0, par_err_o=0; held until ready_i=1 and cleared the next cycle.
- 8E1, div_i=0: send 0x3C with parity bit 1 (wrong) -> data_o=0x3C, par_err_o=1. Send 0x3C with parity 0 -> par_err_o=0. Repeat as 8O1 with parity 1 -> par_err_o=0.
- 8N2: second stop bit driven 0 on 0x55 -> frame_err_o=1, data_o=0x55. Hold the line low for 12 bit times on 8N1 -> data_o=0x00, frame_err_o=1, one break_o pulse, no second frame until the line goes high.
- Glitch rejection: a low pulse of 5 bit-tick periods on an idle line -> START aborts to IDLE, valid_o stays 0, busy_o drops. A single-tick glitch at tick 8 inside data bit 3 -> majority keeps the correct bit.
- Overrun: keep ready_i=0 and send 0x11 then 0x22 back-to-back -> overrun_o pulses once, data_o stays 0x11. Assert ready_i in the completion cycle of a third frame 0x33 -> data_o=0x33 with no overrun.
- Async reset: assert rst_ni mid DATA bit 4 -> all outputs 0 immediately. Release and send 0x7E -> data_o=0x7E, no residue from the aborted frame. DATA_BITS=5 build: send 0x1F -> data_o=5'h1F.

Source files
------------

// File: rtl/as_rx_gen2.sv
`default_nettype none
// ============================================================================
// Module   : as_rx_gen2
// Brief    : UART receiver with 16x oversampling, 2-of-3 majority sampling,
//            runtime parity/stop selection, false-start rejection, framing /
//            parity / break / overrun detection and a valid/ready holding
//            register on the bus side.
// Revision : 1.0 - initial release
// ============================================================================
module as_rx_gen2 #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16,
   parameter int OVS       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   input  logic [DIV_W-1:0]     div_i,
   input  logic [1:0]           par_mode_i,
   input  logic                 stop2_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 frame_err_o,
   output logic                 par_err_o,
   output logic                 break_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int c_tick_w = $clog2(OVS);
   localparam int c_idx_w  = $clog2(DATA_BITS);

   // Majority samples sit around mid-bit of the 16-tick bit period
   localparam logic [c_tick_w-1:0] c_tick_s7   = c_tick_w'(7);
   localparam logic [c_tick_w-1:0] c_tick_s8   = c_tick_w'(8);
   localparam logic [c_tick_w-1:0] c_tick_s9   = c_tick_w'(9);
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVS - 1);
   localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } state_t;

   state_t                r_state;
   logic [1:0]            r_sync;
   logic                  r_rx_prev;
   logic [DIV_W-1:0]      r_div;
   logic                  r_par_en;
   logic                  r_par_odd;
   logic                  r_stop2;
   logic [DIV_W-1:0]      r_div_cnt;
   logic [c_tick_w-1:0]   r_tick_cnt;
   logic                  r_s7;
   logic                  r_s8;
   logic [c_idx_w-1:0]    r_bit_idx;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_all_zero;
   logic                  r_frame_err;
   logic                  r_par_err;
   logic                  r_brk;
   logic                  r_complete;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid;
   logic                  r_out_fe;
   logic                  r_out_pe;
   logic                  r_out_brk;
   logic                  r_out_ovr;

   logic w_rx_s;
   logic w_fall;
   logic w_tick;
   logic w_resolve;
   logic w_bit_end;
   logic w_maj;
   logic w_par_exp;

   assign w_rx_s    = r_sync[1];
   assign w_fall    = r_rx_prev & ~w_rx_s;
   assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == r_div);
   assign w_resolve = w_tick && (r_tick_cnt == c_tick_s9);
   assign w_bit_end = w_tick && (r_tick_cnt == c_tick_last);
   // Third vote is the live synchronised line at tick 9
   assign w_maj     = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);
   assign w_par_exp = r_par_odd ? ~(^r_shift) : (^r_shift);

   // Two-flop synchroniser plus previous-value register for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync    <= {r_sync[0], rx_i};
         r_rx_prev <= w_rx_s;
      end
   end

   // Oversample tick divider; held at zero in IDLE so START begins aligned
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_div_cnt <= '0;
      end else if (r_state == S_IDLE || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   // Tick position within the current bit, 0..OVS-1
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tick_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= (r_tick_cnt == c_tick_last) ? '0 : r_tick_cnt + 1'b1;
      end
   end

   // Capture the first two majority votes at ticks 7 and 8
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_s7 <= 1'b0;
         r_s8 <= 1'b0;
      end else if (w_tick) begin
         if (r_tick_cnt == c_tick_s7) r_s7 <= w_rx_s;
         if (r_tick_cnt == c_tick_s8) r_s8 <= w_rx_s;
      end
   end

   // Frame sequencing: start qualification, bit assembly, parity and stop checks
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_div       <= '0;
         r_par_en    <= 1'b0;
         r_par_odd   <= 1'b0;
         r_stop2     <= 1'b0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_all_zero  <= 1'b0;
         r_frame_err <= 1'b0;
         r_par_err   <= 1'b0;
         r_brk       <= 1'b0;
         r_complete  <= 1'b0;
      end else begin
         r_complete <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state     <= S_START;
                  r_div       <= div_i;
                  r_par_en    <= par_mode_i[0] ^ par_mode_i[1];
                  r_par_odd   <= (par_mode_i == 2'b10);
                  r_stop2     <= stop2_i;
                  r_bit_idx   <= '0;
                  r_shift     <= '0;
                  r_all_zero  <= 1'b1;
                  r_frame_err <= 1'b0;
                  r_par_err   <= 1'b0;
                  r_brk       <= 1'b0;
               end
            end
            S_START: begin
               if (w_resolve && w_maj) begin
                  r_state <= S_IDLE;
               end else if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               // LSB arrives first, so shifting in from the top leaves it at bit 0
               if (w_resolve) begin
                  r_shift    <= {w_maj, r_shift[DATA_BITS-1:1]};
                  r_all_zero <= r_all_zero & ~w_maj;
               end
               if (w_bit_end) begin
                  if (r_bit_idx == c_last_idx) begin
                     r_state <= r_par_en ? S_PARITY : S_STOP1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (w_resolve) begin
                  r_par_err  <= (w_maj != w_par_exp);
                  r_all_zero <= r_all_zero & ~w_maj;
               end
               if (w_bit_end) r_state <= S_STOP1;
            end
            S_STOP1: begin
               if (w_resolve) begin
                  r_frame_err <= ~w_maj;
                  r_brk       <= r_all_zero & ~w_maj;
                  // Single stop bit: finish at mid-bit to tolerate receiver/transmitter skew
                  if (!r_stop2) begin
                     r_complete <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end else if (w_bit_end) begin
                  r_state <= S_STOP2;
               end
            end
            S_STOP2: begin
               if (w_resolve) begin
                  r_frame_err <= r_frame_err | ~w_maj;
                  r_complete  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Holding register: load on completion if empty or drained this cycle, else flag overrun
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_out_fe  <= 1'b0;
         r_out_pe  <= 1'b0;
         r_out_brk <= 1'b0;
         r_out_ovr <= 1'b0;
      end else begin
         r_out_brk <= 1'b0;
         r_out_ovr <= 1'b0;
         if (r_complete) begin
            r_out_brk <= r_brk;
            if (!r_valid || ready_i) begin
               r_data   <= r_shift;
               r_out_fe <= r_frame_err;
               r_out_pe <= r_par_err;
               r_valid  <= 1'b1;
            end else begin
               r_out_ovr <= 1'b1;
            end
         end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign frame_err_o = r_out_fe;
   assign par_err_o   = r_out_pe;
   assign break_o     = r_out_brk;
   assign overrun_o   = r_out_ovr;
   assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_as_rx_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_as_rx_gen2
// Brief    : Self-checking bench for as_rx_gen2 (8-bit and 5-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_as_rx_gen2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tx;
   logic        sel5;
   logic [15:0] div;
   logic [1:0]  par_mode;
   logic        stop2;
   logic        ready;
   logic        ready5;
   logic        rx8;
   logic        rx5;

   logic [7:0]  data_o;
   logic        valid_o, frame_err_o, par_err_o, break_o, overrun_o, busy_o;
   logic [4:0]  data5;
   logic        valid5, fe5, pe5, brk5, ovr5, busy5;

   int d;
   int n_pass = 0;
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int rise_cyc = 0;
   int t0 = 0;
   int n_brk = 0;
   int n_ovr = 0;
   logic valid_q = 1'b0;

   assign rx8 = sel5 ? 1'b1 : tx;
   assign rx5 = sel5 ? tx : 1'b1;

   always #5 clk = ~clk;

   as_rx_gen2 #(.DATA_BITS(8), .DIV_W(16), .OVS(16)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(rx8), .div_i(div),
      .par_mode_i(par_mode), .stop2_i(stop2), .data_o(data_o),
      .valid_o(valid_o), .ready_i(ready), .frame_err_o(frame_err_o),
      .par_err_o(par_err_o), .break_o(break_o), .overrun_o(overrun_o),
      .busy_o(busy_o)
   );

   as_rx_gen2 #(.DATA_BITS(5), .DIV_W(16), .OVS(16)) u_dut5 (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(rx5), .div_i(div),
      .par_mode_i(par_mode), .stop2_i(stop2), .data_o(data5),
      .valid_o(valid5), .ready_i(ready5), .frame_err_o(fe5),
      .par_err_o(pe5), .break_o(brk5), .overrun_o(ovr5),
      .busy_o(busy5)
   );

   // Free-running cycle count and pulse/rise monitors
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (valid_o && !valid_q) rise_cyc = cyc;
      valid_q = valid_o;
      if (break_o)   n_brk++;
      if (overrun_o) n_ovr++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Parity bit a correct transmitter would send
   function automatic logic good_par(input logic [8:0] data, input int nbits, input logic odd);
      int ones;
      ones = 0;
      for (int i = 0; i < nbits; i++) ones += int'(data[i]);
      return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   // Serialise one frame at 16*(d+1) clocks per bit; optional tick-8 glitch
   // inside a data bit and optional early stop after max_clks clocks.
   task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                             input logic par_bit, input int nstop, input logic st1,
                             input logic st2, input int glitch_bit, input int max_clks);
      logic lv[$];
      int   bitclk;
      int   n;
      bitclk = 16 * (d + 1);
      n = 0;
      lv.push_back(1'b0);
      for (int i = 0; i < nbits; i++) lv.push_back(data[i]);
      if (has_par) lv.push_back(par_bit);
      lv.push_back(st1);
      if (nstop == 2) lv.push_back(st2);
      for (int b = 0; b < lv.size(); b++) begin
         for (int k = 0; k < bitclk; k++) begin
            @(negedge clk);
            if (max_clks > 0 && n >= max_clks) begin
               tx = 1'b1;
               return;
            end
            if (b == 0 && k == 0) t0 = cyc;
            tx = lv[b];
            if (glitch_bit >= 0 && b == glitch_bit + 1 &&
                k >= 8 * (d + 1) + 1 && k <= 9 * (d + 1)) tx = ~lv[b];
            n++;
         end
      end
      @(negedge clk);
      tx = 1'b1;
   endtask

   task automatic expect_frame(input string tag, input logic [8:0] exp_d,
                               input logic exp_fe, input logic exp_pe);
      int w;
      w = 0;
      while (!valid_o && w < 3000) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_valid"}, 32'(valid_o), 32'd1);
      chk({tag, "_data"},  32'(data_o), 32'(exp_d));
      chk({tag, "_ferr"},  32'(frame_err_o), 32'(exp_fe));
      chk({tag, "_perr"},  32'(par_err_o), 32'(exp_pe));
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk({tag, "_clr"}, 32'(valid_o), 32'd0);
   endtask

   initial begin
      int b0;
      int w;
      rst_n = 1'b0; tx = 1'b1; sel5 = 1'b0; div = '0; par_mode = 2'b00;
      stop2 = 1'b0; ready = 1'b0; ready5 = 1'b0; d = 0;
      repeat (3) @(negedge clk);
      chk("rst_data",  32'(data_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_ferr",  32'(frame_err_o), 32'd0);
      chk("rst_perr",  32'(par_err_o), 32'd0);
      chk("rst_brk",   32'(break_o), 32'd0);
      chk("rst_ovr",   32'(overrun_o), 32'd0);
      chk("rst_busy",  32'(busy_o), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 at 64 clocks per bit, with completion latency
      d = 3; div = 16'(d);
      send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0);
      chk("t1_latency", 32'(rise_cyc - t0), 32'(4 + (16 * 9 + 10) * (d + 1)));
      expect_frame("t1", 9'h0A5, 1'b0, 1'b0);

      // Parity: even wrong, even right, odd right
      d = 0; div = 16'(d); par_mode = 2'b01;
      send_frame(9'h03C, 8, 1, 1'b1, 1, 1'b1, 1'b1, -1, 0);
      expect_frame("even_bad", 9'h03C, 1'b0, 1'b1);
      send_frame(9'h03C, 8, 1, 1'b0, 1, 1'b1, 1'b1, -1, 0);
      expect_frame("even_ok", 9'h03C, 1'b0, 1'b0);
      par_mode = 2'b10;
      send_frame(9'h03C, 8, 1, 1'b1, 1, 1'b1, 1'b1, -1, 0);
      expect_frame("odd_ok", 9'h03C, 1'b0, 1'b0);

      // 8N2 with bad second stop bit
      par_mode = 2'b00; stop2 = 1'b1;
      send_frame(9'h055, 8, 0, 1'b0, 2, 1'b1, 1'b0, -1, 0);
      expect_frame("stop2_bad", 9'h055, 1'b1, 1'b0);

      // Line held low for 12 bit times: one break frame only
      stop2 = 1'b0; d = 1; div = 16'(d);
      b0 = n_brk;
      @(negedge clk); tx = 1'b0;
      repeat (12 * 16 * (d + 1)) @(negedge clk);
      tx = 1'b1;
      expect_frame("brk", 9'h000, 1'b1, 1'b0);
      chk("brk_pulses", 32'(n_brk - b0), 32'd1);
      repeat (3 * 16 * (d + 1)) @(negedge clk);
      chk("brk_no_second", 32'(valid_o), 32'd0);

      // False start: 5-tick low pulse on idle line
      d = 3; div = 16'(d);
      @(negedge clk); tx = 1'b0;
      repeat (4 * (d + 1)) @(negedge clk);
      chk("fs_busy", 32'(busy_o), 32'd1);
      repeat (d + 1) @(negedge clk);
      tx = 1'b1;
      repeat (16 * (d + 1)) @(negedge clk);
      chk("fs_idle", 32'(busy_o), 32'd0);
      chk("fs_novalid", 32'(valid_o), 32'd0);

      // Tick-8 glitch inside data bit 3
      send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, 3, 0);
      expect_frame("glitch", 9'h0A5, 1'b0, 1'b0);

      // Overrun, then a third frame drained in its completion cycle
      d = 0; div = 16'(d);
      b0 = n_ovr;
      send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0);
      send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0);
      repeat (2) @(negedge clk);
      chk("ovr_pulses", 32'(n_ovr - b0), 32'd1);
      chk("ovr_valid", 32'(valid_o), 32'd1);
      chk("ovr_keep", 32'(data_o), 32'h11);
      fork
         send_frame(9'h033, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0);
         begin
            @(negedge clk);
            repeat (3 + 154 * (d + 1)) @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      chk("same_cyc_valid", 32'(valid_o), 32'd1);
      chk("same_cyc_data", 32'(data_o), 32'h33);
      chk("same_cyc_noovr", 32'(n_ovr - b0), 32'd1);

      // Asynchronous reset in the middle of data bit 4
      d = 1; div = 16'(d);
      send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 16 * (d + 1) * 5 + 8 * (d + 1));
      chk("pre_rst_busy", 32'(busy_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", 32'(data_o), 32'd0);
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_flags", 32'({frame_err_o, par_err_o, break_o, overrun_o}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * 16 * (d + 1)) @(negedge clk);
      chk("arst_no_residue", 32'(valid_o), 32'd0);
      send_frame(9'h07E, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0);
      expect_frame("post_rst", 9'h07E, 1'b0, 1'b0);

      // 5-bit build
      d = 0; div = 16'(d); sel5 = 1'b1;
      send_frame(9'h01F, 5, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0);
      w = 0;
      while (!valid5 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("db5_valid", 32'(valid5), 32'd1);
      chk("db5_data", 32'(data5), 32'h1F);
      sel5 = 1'b0;

      // Randomised frames against a frame-level reference model
      for (int i = 0; i < 16; i++) begin
         logic [7:0] rd;
         int         pm;
         int         ns;
         bit         hp;
         logic       pb, s1, s2, fe_e, pe_e, brk_e;
         rd = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) rd = 8'h00;
         pm = int'($urandom_range(0, 3));
         d  = int'($urandom_range(0, 2));
         div = 16'(d);
         par_mode = 2'(pm);
         hp = (pm == 1 || pm == 2);
         pb = good_par({1'b0, rd}, 8, pm == 2) ^ ($urandom_range(0, 3) == 0);
         ns = int'($urandom_range(1, 2));
         stop2 = (ns == 2);
         s1 = ($urandom_range(0, 3) != 0);
         s2 = ($urandom_range(0, 3) != 0);
         pe_e  = hp && (pb != good_par({1'b0, rd}, 8, pm == 2));
         fe_e  = !s1 || (ns == 2 && !s2);
         brk_e = (rd == 8'h00) && (!hp || !pb) && !s1;
         b0 = n_brk;
         send_frame({1'b0, rd}, 8, hp, pb, ns, s1, s2, -1, 0);
         expect_frame("rnd", {1'b0, rd}, fe_e, pe_e);
         chk("rnd_brk", 32'(n_brk - b0), 32'(brk_e));
         repeat (16 * (d + 1)) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
